// File: rtl/triage_pkg.sv
// Shared types and defaults for the triage priority queue.
package triage_pkg;

  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned PRIO_W_DEF = 2;
  localparam int unsigned ID_W_DEF   = 4;

  // Entry fields are sized to the widest supported configuration; narrower
  // instances zero-extend on write and slice on read.
  localparam int unsigned ID_W_MAX   = 16;
  localparam int unsigned PRIO_W_MAX = 8;

  typedef struct packed {
    logic [ID_W_MAX-1:0]   id;
    logic [PRIO_W_MAX-1:0] prio;
  } entry_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/triage_pqueue_prio_select.sv
// Combinational pick of the most urgent occupied slot; ties go to the lowest index.
module prio_select
  import triage_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic   [DEPTH-1:0] occ_mask,
  output logic   [IDX_W-1:0] sel_idx,
  output logic               hit
);

  logic [PRIO_W_MAX-1:0] best_prio;
  entry_t [DEPTH-1:0]    unused_entries;

  assign unused_entries = entries;

  // Strict greater-than keeps the earliest slot among equal priorities.
  always_comb begin
    hit       = 1'b0;
    sel_idx   = '0;
    best_prio = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occ_mask[i] && (!hit || entries[i].prio > best_prio)) begin
        hit       = 1'b1;
        best_prio = entries[i].prio;
        sel_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/triage_pqueue.sv
// Patient priority queue: arrival-ordered slot array, priority-first service, FIFO within a level.
module triage_pqueue
  import triage_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned PRIO_W = PRIO_W_DEF,
  parameter int unsigned ID_W   = ID_W_DEF,
  parameter int unsigned CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [ID_W-1:0]   enq_id,
  input  logic [PRIO_W-1:0] enq_prio,
  input  logic              deq_req,
  output logic              deq_valid,
  output logic [ID_W-1:0]   deq_id,
  output logic [PRIO_W-1:0] deq_prio,
  output logic              deq_err,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  entry_t [DEPTH-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             deq_q, deq_d;
  logic               deq_valid_q, deq_valid_d;
  logic               deq_err_q, deq_err_d;

  logic [DEPTH-1:0]   occ_mask;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_hit;
  logic               enq_fire, deq_fire;
  logic [CNT_W-1:0]   wr_idx;
  entry_t             new_entry;
  entry_t             unused_deq;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign enq_ready = !full;
  assign count     = count_q;
  assign deq_valid = deq_valid_q;
  assign deq_err   = deq_err_q;
  assign deq_id    = deq_q.id[ID_W-1:0];
  assign deq_prio  = deq_q.prio[PRIO_W-1:0];
  assign unused_deq = deq_q;

  always_comb begin
    occ_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_mask[i] = (CNT_W'(i) < count_q);
    end
  end

  prio_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_prio_select (
    .entries  (slots_q),
    .occ_mask (occ_mask),
    .sel_idx  (sel_idx),
    .hit      (sel_hit)
  );

  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_req && !empty && sel_hit;
  assign new_entry = '{id: ID_W_MAX'(enq_id), prio: PRIO_W_MAX'(enq_prio)};
  // A same-cycle enqueue lands behind the shifted-down survivors.
  assign wr_idx    = deq_fire ? (count_q - CNT_W'(1)) : count_q;

  always_comb begin
    slots_d     = slots_q;
    count_d     = count_q;
    deq_d       = deq_q;
    deq_valid_d = deq_fire;
    deq_err_d   = deq_req && empty;

    if (deq_fire) begin
      deq_d = slots_q[sel_idx];
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          slots_d[i] = slots_q[i+1];
        end
      end
    end

    if (enq_fire) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) begin
          slots_d[i] = new_entry;
        end
      end
    end

    if (enq_fire && !deq_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (deq_fire && !enq_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    slots_q <= slots_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      deq_q       <= '0;
      deq_valid_q <= 1'b0;
      deq_err_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      deq_q       <= deq_d;
      deq_valid_q <= deq_valid_d;
      deq_err_q   <= deq_err_d;
    end
  end

endmodule

// File: doc/triage_pqueue.md
TRIAGE_PQUEUE -- requirements
Module: triage_pqueue

Interface
REQ-001 Parameter DEPTH, default 16: patient capacity, at least 2.
REQ-002 Parameter PRIO_W, default 2: priority width; a larger value means more urgent.
REQ-003 Parameter ID_W, default 4: patient ID width.
REQ-004 Parameter CNT_W, default $clog2(DEPTH+1): occupancy width.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port enq_valid, input, 1: an admission request is present.
REQ-008 Port enq_ready, output, 1: room available; equals !full.
REQ-009 Port enq_id, input, ID_W: patient ID.
REQ-010 Port enq_prio, input, PRIO_W: patient priority.
REQ-011 Port deq_req, input, 1: the doctor is ready for the next patient.
REQ-012 Port deq_valid, output, 1: one-cycle pulse; deq_id and deq_prio are valid.
REQ-013 Port deq_id, output, ID_W: ID of the patient sent for treatment.
REQ-014 Port deq_prio, output, PRIO_W: priority of that patient.
REQ-015 Port deq_err, output, 1: one-cycle pulse; deq_req arrived while the queue was empty.
REQ-016 Port count, output, CNT_W: current occupancy.
REQ-017 Ports full and empty, outputs, 1 each: count==DEPTH and count==0 respectively.

Function
REQ-018 Enqueue is accepted when enq_valid && enq_ready at a clock edge; the entry is stored at slot index count (arrival order).
REQ-019 Dequeue is accepted when deq_req && !empty; selection is combinational over the current occupied slots only.
REQ-020 Selection picks the highest priority; among equal priorities it picks the lowest slot index (oldest arrival). Service is FIFO-stable within a priority level.
REQ-021 On an accepted dequeue, the selected slot is removed and all higher slots shift down by one in the same edge; occupied slots stay contiguous from slot 0.
REQ-022 deq_valid, deq_id and deq_prio are registered and asserted on the edge that accepts the dequeue, so they are visible in the following cycle. deq_id and deq_prio hold their values when deq_valid is low.
REQ-023 For simultaneous accepted enqueue and dequeue:
  - the new entry is not a candidate in that cycle;
  - the new entry lands at slot count-1 after the shift;
  - count is unchanged.
REQ-024 Enqueue when full is not accepted, because enq_ready is low, even if a dequeue occurs in the same cycle; no entry is overwritten.
REQ-025 deq_req while empty:
  - deq_err pulses for one cycle;
  - deq_valid stays low;
  - count stays 0, with no underflow.
REQ-026 count changes as follows: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither occur. It never exceeds DEPTH and never wraps.
REQ-027 full, empty and enq_ready are decoded combinationally from registered count.

Reset
REQ-028 While rst_n is low, asynchronously:
  - count=0, empty=1, full=0, enq_ready=1;
  - deq_valid=0, deq_err=0, deq_id=0, deq_prio=0.
REQ-029 Reset mid-operation discards all stored patients. Slot contents need no reset because they are qualified by count.
REQ-030 Deassertion of rst_n is not required to be synchronised inside the block; the integrator provides a synchronised release.

Structure
REQ-031 Package triage_pkg holds:
  - the entry struct {id, prio};
  - the default parameter constants;
  - a function for the count width.
REQ-032 Sub-module prio_select is the only sub-module. It is combinational: it takes the entries and an occupancy mask, and returns the selected index plus a hit flag, with the lowest-index tie-break.
REQ-033 All storage is a flop array of DEPTH entries; no memory macro.

Verification
REQ-034 Ordering test, DEPTH=4, one enqueue per cycle:
  - enqueue (id,prio) = (1,1), (2,3), (3,3), (4,0);
  - then deq_req for 4 cycles;
  - required deq_id order: 2, 3, 1, 4; count steps 4,3,2,1,0, then empty=1.
REQ-035 Full test, DEPTH=4:
  - enqueue 4 entries, then hold enq_valid with id 9 for 2 cycles;
  - required: full=1, enq_ready=0, count stays 4, id 9 is never dequeued.
REQ-036 Simultaneous test:
  - queue holds (5,2);
  - in the same cycle, enqueue (6,3) with deq_req=1;
  - required: deq_id=5, count stays 1;
  - the next dequeue returns 6.
REQ-037 Empty test:
  - deq_req on an empty queue;
  - required: deq_err=1 for exactly one cycle, deq_valid=0, count=0.
REQ-038 Reset test:
  - with 3 entries queued, pulse rst_n low mid-cycle;
  - required: count=0 and empty=1 immediately, without waiting for a clock edge;
  - a subsequent deq_req gives deq_err=1.
